adder_stream_stage: RTL

ADDER_STREAM_STAGE -- requirements
Module: adder_stream_stage

---
 rtl/adder_stream_pkg.sv | 17 +
 rtl/N_bit_adder.sv | 14 +
 rtl/adder_result_fifo.sv | 63 ++++++
 rtl/adder_stream_stage.sv | 101 ++++++++++
 4 files changed

// File: rtl/adder_stream_pkg.sv
// Shared defaults, result entry type and counter limit for the adder stream stage.
package adder_stream_pkg;

    localparam int unsigned DEFAULT_M     = 4;
    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam logic [7:0]  OVF_CNT_MAX   = 8'd255;

    typedef struct packed {
        logic                 ovf;
        logic [DEFAULT_M-1:0] sum;
    } entry_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == OVF_CNT_MAX) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/N_bit_adder.sv
// Plain unsigned N-bit adder; the carry-out is returned as the MSB of sum_o.
module N_bit_adder #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N:0]   sum_o
);

    always_comb begin
        sum_o = {1'b0, a_i} + {1'b0, b_i};
    end

endmodule

// File: rtl/adder_result_fifo.sv
// Result FIFO: register-array storage with wrapping pointers and an occupancy count.
module adder_result_fifo #(
    parameter int unsigned  Width = 5,
    parameter int unsigned  Depth = 4,
    localparam int unsigned PtrW  = $clog2(Depth),
    localparam int unsigned LvlW  = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             empty_o,
    output logic [LvlW-1:0]  level_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             full, do_push, do_pop;

    always_comb begin
        full     = (level_q == LvlW'(Depth));
        do_pop   = pop_i && (level_q != '0);
        // A push into a full FIFO is only legal when the head leaves on the same edge.
        do_push  = push_i && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = mem_q[rd_ptr_q];
        empty_o = (level_q == '0);
        level_o = level_q;
    end

endmodule

// File: rtl/adder_stream_stage.sv
// Streaming adder: operand register -> N_bit_adder -> result FIFO, with ready/valid on
// both sides and a saturating count of overflowed results.
module adder_stream_stage
    import adder_stream_pkg::*;
#(
    parameter int unsigned M     = DEFAULT_M,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [M-1:0]           in_a,
    input  logic [M-1:0]           in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [M-1:0]           out_sum,
    output logic                   out_ovf,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             ovf_cnt
);

    localparam int unsigned LvlW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic         ovf;
        logic [M-1:0] sum;
    } res_t;

    logic            op_vld_q, op_vld_d;
    logic [M-1:0]    op_a_q, op_a_d;
    logic [M-1:0]    op_b_q, op_b_d;
    logic            rdy_en_q;
    logic [7:0]      ovf_cnt_q, ovf_cnt_d;
    logic [M:0]      add_res;
    res_t            push_entry;
    res_t            head_entry;
    logic            accept, push, pop;
    logic            fifo_empty;
    logic [LvlW-1:0] fifo_level;

    N_bit_adder #(
        .N (M)
    ) u_adder (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sum_o (add_res)
    );

    adder_result_fifo #(
        .Width (M + 1),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        // Reserve a slot for the operand in flight so a push never meets a full FIFO.
        in_ready   = rdy_en_q && ((fifo_level + LvlW'(op_vld_q)) < LvlW'(DEPTH));
        accept     = in_valid && in_ready;
        push       = op_vld_q;
        out_valid  = !fifo_empty;
        pop        = out_valid && out_ready;
        push_entry.ovf = add_res[M];
        push_entry.sum = add_res[M-1:0];

        op_vld_d  = accept;
        op_a_d    = accept ? in_a : op_a_q;
        op_b_d    = accept ? in_b : op_b_q;
        ovf_cnt_d = (push && add_res[M]) ? sat_inc(ovf_cnt_q) : ovf_cnt_q;

        out_sum = out_valid ? head_entry.sum : '0;
        out_ovf = out_valid ? head_entry.ovf : 1'b0;
        level   = fifo_level;
        ovf_cnt = ovf_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_vld_q  <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rdy_en_q  <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            op_vld_q  <= op_vld_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            rdy_en_q  <= 1'b1;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

endmodule
